// File: rtl/cpu_pkg.sv
// Shared CPU package: read-return state encoding and the default
// debug-port starvation limit used by the DRAM arbiter.
package cpu_pkg;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_C    = 2'd1,
    RD_D    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dram_arbiter.sv
// Single-port DRAM arbiter between the CPU MEM stage and the debug/loader port.
// CPU has default priority; a starved debug port is forced through after STARVE_LIMIT denials.
module dram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic [3:0]        c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  rd_state_e         rd_state_q, rd_state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              c_gnt_s, d_gnt_s, dbg_force_s;

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    dbg_force_s = d_req && (starve_q == CNT_MAX);
    c_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    if (rst_n) begin
      if (dbg_force_s) begin
        d_gnt_s = 1'b1;
      end else if (c_req) begin
        c_gnt_s = 1'b1;
      end else if (d_req) begin
        d_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b0;
      end
    end else begin
      c_gnt_s = 1'b0;
    end
  end

  // Starvation counter, DRAM port mux and read-return next state
  always_comb begin
    starve_d   = '0;
    m_en       = c_gnt_s | d_gnt_s;
    m_we       = 4'b0000;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_state_d = RD_NONE;
    if (d_req && !d_gnt_s) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
    end else begin
      starve_d = '0;
    end
    if (c_gnt_s) begin
      m_we       = c_we;
      addr_d     = c_addr;
      wdata_d    = c_wdata;
      rd_state_d = (c_we == 4'b0000) ? RD_C : RD_NONE;
    end else if (d_gnt_s) begin
      m_we       = d_we;
      addr_d     = d_addr;
      wdata_d    = d_wdata;
      rd_state_d = (d_we == 4'b0000) ? RD_D : RD_NONE;
    end else begin
      rd_state_d = RD_NONE;
    end
    m_addr  = addr_d;
    m_wdata = wdata_d;
  end

  // State register: synchronous active-low reset drops any read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RD_NONE;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
    end else begin
      rd_state_q <= rd_state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Read-return outputs, steered by the port that issued last cycle's read
  always_comb begin
    c_gnt    = c_gnt_s;
    d_gnt    = d_gnt_s;
    c_stall  = rst_n & c_req & ~c_gnt_s;
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    c_rdata  = 32'h0000_0000;
    d_rdata  = 32'h0000_0000;
    case (rd_state_q)
      RD_C: begin
        c_rvalid = rst_n;
        c_rdata  = rst_n ? m_rdata : 32'h0000_0000;
      end
      RD_D: begin
        d_rvalid = rst_n;
        d_rdata  = rst_n ? m_rdata : 32'h0000_0000;
      end
      default: begin
        c_rvalid = 1'b0;
        d_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter with a registered-read DRAM model.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, d_req;
  logic [3:0]  c_we, d_we;
  logic [15:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0000_0000;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;
  logic prev_c, prev_d, exp_d;

  dram_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // DRAM model: byte-strobed write, registered read
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we == 4'b0000) begin
        m_rdata <= mem[m_addr[9:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[9:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [3:0] cw, input logic [15:0] ca,
                       input logic [31:0] cd, input logic dr, input logic [3:0] dw,
                       input logic [15:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[16'h0010] = 32'hDEAD_BEEF;
    mem[16'h0001] = 32'hA5A5_0001;
    mem[16'h0002] = 32'h5A5A_0002;

    // Reset with both requests asserted: everything gated off
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 4'b0000; c_addr = 16'h0010; c_wdata = 32'h0;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 16'h0002; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_c_stall", c_stall, 0);
    chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);

    // CPU single read
    @(posedge clk); #1; rst_n = 1'b1;
    c_req = 1'b1; c_we = 4'b0000; c_addr = 16'h0010; d_req = 1'b0;
    @(negedge clk);
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_c_stall", c_stall, 0);
    chk("rd_m_en", m_en, 1);
    chk("rd_m_addr", m_addr, 32'h0010);
    chk("rd_c_rvalid_early", c_rvalid, 0);
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("rd_d_rvalid", d_rvalid, 0);
    chk("rd_idle_m_en", m_en, 0);

    // Contention: CPU 4 grants, then debug once, repeating
    prev_c = 1'b0; prev_d = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 4'b0, 16'h0010, 32'h0, 1'b1, 4'b0, 16'h0002, 32'h0);
      exp_d = (k % 5 == 0);
      chk($sformatf("cont_d_gnt_%0d", k), d_gnt, exp_d);
      chk($sformatf("cont_c_gnt_%0d", k), c_gnt, !exp_d);
      chk($sformatf("cont_c_stall_%0d", k), c_stall, exp_d);
      chk($sformatf("cont_c_rvalid_%0d", k), c_rvalid, prev_c);
      chk($sformatf("cont_d_rvalid_%0d", k), d_rvalid, prev_d);
      chk($sformatf("cont_c_rdata_%0d", k), c_rdata, prev_c ? 32'hDEAD_BEEF : 32'h0);
      chk($sformatf("cont_d_rdata_%0d", k), d_rdata, prev_d ? 32'h5A5A_0002 : 32'h0);
      prev_c = !exp_d; prev_d = exp_d;
    end
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("cont_tail_d_rvalid", d_rvalid, 1);
    chk("cont_tail_d_rdata", d_rdata, 32'h5A5A_0002);

    // Alternating reads return in grant order with no bubble
    drive(1'b1, 4'b0, 16'h0001, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("alt_c_gnt", c_gnt, 1);
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b1, 4'b0, 16'h0002, 32'h0);
    chk("alt_d_gnt", d_gnt, 1);
    chk("alt_c_rvalid", c_rvalid, 1);
    chk("alt_c_rdata", c_rdata, 32'hA5A5_0001);
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("alt_d_rvalid", d_rvalid, 1);
    chk("alt_d_rdata", d_rdata, 32'h5A5A_0002);
    chk("alt_c_rvalid_off", c_rvalid, 0);

    // Debug halfword write, then CPU reads it back
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b1, 4'b0011, 16'h0100, 32'h1234_5678);
    chk("wr_d_gnt", d_gnt, 1);
    chk("wr_m_we", m_we, 4'b0011);
    chk("wr_m_addr", m_addr, 32'h0100);
    chk("wr_m_wdata", m_wdata, 32'h1234_5678);
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("wr_no_d_rvalid", d_rvalid, 0);
    chk("wr_idle_m_we", m_we, 4'b0000);
    chk("wr_hold_m_addr", m_addr, 32'h0100);
    chk("wr_hold_m_wdata", m_wdata, 32'h1234_5678);
    drive(1'b1, 4'b0, 16'h0100, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("wr_rd_c_gnt", c_gnt, 1);
    drive(1'b0, 4'b0, 16'h0, 32'h0, 1'b0, 4'b0, 16'h0, 32'h0);
    chk("wr_rd_c_rdata", c_rdata, 32'h0000_5678);

    // Build starvation to the limit, reset mid-read, CPU must win again
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'b0, 16'h0010, 32'h0, 1'b1, 4'b0, 16'h0002, 32'h0);
      chk($sformatf("pre_c_gnt_%0d", k), c_gnt, 1);
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_c_rvalid", c_rvalid, 0);
    chk("mid_rst_c_gnt", c_gnt, 0);
    chk("mid_rst_m_en", m_en, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_c_rvalid", c_rvalid, 0);
    chk("post_rst_c_gnt", c_gnt, 1);
    chk("post_rst_d_gnt", d_gnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 16, word-address width
- STARVE_LIMIT, 4, consecutive debug-port denials before the debug port is forced priority
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: clock
- rst_n in 1: reset, synchronous, active-low
- c_req in 1: CPU MEM-stage access request
- c_we in 4: CPU byte write strobe; 0 means read
- c_addr in ADDR_W: CPU word address
- c_wdata in 32: CPU write data
- c_gnt out 1: CPU access accepted this cycle
- c_stall out 1: CPU pipeline stall
- c_rvalid out 1: CPU read data valid
- c_rdata out 32: CPU read data
- d_req, d_we, d_addr, d_wdata in 1/4/ADDR_W/32: debug/loader port request, same meaning as the CPU port
- d_gnt, d_rvalid out 1; d_rdata out 32: debug port response
- m_en out 1: DRAM access enable
- m_we out 4: DRAM byte strobe
- m_addr out ADDR_W: DRAM address
- m_wdata out 32: DRAM write data
- m_rdata in 32: DRAM read data, registered, valid one cycle after m_en with m_we==0

Function
REQ-003 At most one DRAM access per cycle; grant is combinational from the current requests and the registered priority state.
REQ-004 Default priority is CPU: if c_req, grant CPU; otherwise grant debug when d_req.
REQ-005 Starvation counter (width clog2(STARVE_LIMIT+1)) increments each cycle d_req=1 and d_gnt=0; it clears when d_gnt=1 or d_req=0; it saturates at STARVE_LIMIT.
REQ-006 When the counter equals STARVE_LIMIT and d_req=1, debug wins that cycle even if c_req=1.
REQ-007 c_stall=c_req&~c_gnt; a stalled CPU holds its request unchanged, and the arbiter does not depend on that.
REQ-008 The granted port's we/addr/wdata drive m_*; m_en=c_gnt|d_gnt. With no grant, m_en=0, m_we=0, and addr/wdata hold their last value.
REQ-009 Read-return FSM states: RD_NONE, RD_C, RD_D. The next state is RD_C or RD_D on a granted read (we==0) from that port; otherwise RD_NONE.
REQ-010 In RD_C: c_rvalid=1 and c_rdata=m_rdata. In RD_D: d_rvalid=1 and d_rdata=m_rdata. Otherwise both rvalid=0 and rdata=0.
REQ-011 Read latency is exactly 1 cycle after grant. Back-to-back grants to alternating ports return in grant order with no bubble.
REQ-012 Writes complete in the grant cycle and produce no rvalid.
REQ-013 c_gnt and d_gnt are never both 1.

Reset
REQ-014 While rst_n=0 at a clock edge: state=RD_NONE, starvation counter=0, and all gnt/rvalid/stall outputs and m_en are 0.
REQ-015 Any read in flight when reset asserts is discarded, and no rvalid follows reset release.

Structure
REQ-016 The rd_state_e enum and the STARVE_LIMIT default live in the shared CPU package (cpu_pkg).
REQ-017 The block is a single module with no sub-modules; CPU_TOP instantiates it between the MEM stage and DRAM.

Verification
REQ-018 CPU read only: c_req=1, c_we=0, c_addr=0x0010, DRAM word=0xDEADBEEF -> c_gnt=1 in the same cycle, then c_rvalid=1 and c_rdata=0xDEADBEEF the next cycle, with c_stall=0.
REQ-019 Contention: c_req and d_req held at 1 continuously -> CPU is granted 4 cycles, debug is granted on the 5th, and the pattern repeats; c_stall=1 only in debug-grant cycles.
REQ-020 Alternating reads: CPU reads 0x0001, debug reads 0x0002 the next cycle -> c_rvalid then d_rvalid in consecutive cycles, each with the correct data.
REQ-021 Debug write: d_we=4'b0011, d_addr=0x0100, d_wdata=0x12345678 -> m_we=0011 for one cycle, no d_rvalid; a subsequent CPU read of 0x0100 returns the low halfword 0x5678.
REQ-022 Reset during an in-flight CPU read -> no c_rvalid after reset release, the counter is 0, and the CPU wins the first contended cycle.
